// File: rtl/clkgen_multiphase_pkg.sv
// rtl/clkgen_multiphase_pkg.sv - shared state type, constants and phase helper for clkgen_multiphase
package clkgen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      LOCK = 2'd2
   } clk_state_t;

   localparam int MIN_DIV = 2;
   localparam int POS_W   = 32;

   // Distance of cnt past a channel's phase point, wrapped into 0..div-1.
   // Operands are widened to POS_W so any counter width can use it.
   function automatic logic [POS_W-1:0] phase_pos(input logic [POS_W-1:0] cnt,
                                                  input logic [POS_W-1:0] ph,
                                                  input logic [POS_W-1:0] div);
      if (cnt >= ph) begin
         return cnt - ph;
      end
      return cnt + div - ph;
   endfunction

endpackage

// File: rtl/clkgen_multiphase_if.sv
// rtl/clkgen_multiphase_if.sv - reconfiguration handshake bundle (divisor + per-channel phases)
interface clkgen_multiphase_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 8
);
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [CNT_W-1:0]        cfg_div;
   logic [NUM_CH*CNT_W-1:0] cfg_phase;
   logic                    cfg_err;

   modport master (
      output cfg_valid, cfg_div, cfg_phase,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_div, cfg_phase,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/clkgen_multiphase_phase_chan.sv
// rtl/clkgen_multiphase_phase_chan.sv - one output channel: phase-shifted compare driving registered clock and rise strobe
module clkgen_phase_chan
   import clkgen_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] div,
   input  logic [CNT_W-1:0] ph,
   output logic             outclk,
   output logic             outclk_stb
);

   logic [POS_W-1:0] pos;

   assign pos = phase_pos(POS_W'(cnt), POS_W'(ph), POS_W'(div));

   // High for the first floor(div/2) positions, so odd divisors run short-high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outclk     <= 1'b0;
         outclk_stb <= 1'b0;
      end else begin
         outclk     <= run && (pos < POS_W'(div >> 1));
         outclk_stb <= run && (pos == '0);
      end
   end

endmodule

// File: rtl/clkgen_multiphase.sv
// rtl/clkgen_multiphase.sv - multiphase clock-enable generator; CLKGEN_PHASE_STEP_EN adds single-step phase nudging in LOCK
module clkgen_multiphase
   import clkgen_pkg::*;
#(
   parameter int NUM_CH        = 2,
   parameter int CNT_W         = 8,
   parameter int DIV_DEFAULT   = 6,
   parameter int PHASE_DEFAULT = 0,
   parameter int LOCK_PERIODS  = 4
) (
   input  logic                refclk,
   input  logic                rst_n,
   input  logic                enable,
   clkgen_multiphase_if.slave  cfg,
`ifdef CLKGEN_PHASE_STEP_EN
   input  logic                step_valid,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] step_ch,
   input  logic                step_dir,
`endif
   output logic [NUM_CH-1:0]   outclk,
   output logic [NUM_CH-1:0]   outclk_stb,
   output logic                locked
);

   localparam int LCW = $clog2(LOCK_PERIODS + 1);
   localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_PERIODS - 1);
   localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_DEFAULT);
   localparam logic [CNT_W-1:0] PH_INIT   = CNT_W'(PHASE_DEFAULT);
   localparam logic [CNT_W-1:0] PH1_INIT  = CNT_W'(DIV_DEFAULT / 2);

   clk_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div;
   logic [CNT_W-1:0] ph [NUM_CH];
   logic [LCW-1:0]   lock_cnt;
   logic             cfg_ready_q;
   logic             cfg_err_q;

   logic [CNT_W-1:0] new_ph [NUM_CH];
   logic             cfg_ok;
   logic             xfer;
   logic             wrap;
   logic             chan_run;

   assign cfg.cfg_ready = cfg_ready_q;
   assign cfg.cfg_err   = cfg_err_q;
   assign xfer          = cfg.cfg_valid && cfg_ready_q;
   assign wrap          = (cnt == div - 1'b1);
   assign chan_run      = enable && (state != IDLE);

   always_comb begin
      cfg_ok = (cfg.cfg_div >= CNT_W'(MIN_DIV));
      for (int i = 0; i < NUM_CH; i++) begin
         new_ph[i] = cfg.cfg_phase[i*CNT_W +: CNT_W];
         if (new_ph[i] >= cfg.cfg_div) begin
            cfg_ok = 1'b0;
         end
      end
   end

`ifdef CLKGEN_PHASE_STEP_EN
   logic             step_ok;
   logic [CNT_W-1:0] step_cur;
   logic [CNT_W-1:0] step_next;

   // A concurrent cfg transfer takes precedence over a step.
   assign step_ok  = step_valid && (state == LOCK) && !xfer && (32'(step_ch) < NUM_CH);
   assign step_cur = ph[step_ch];

   always_comb begin
      step_next = step_cur;
      if (step_dir) begin
         step_next = (step_cur == div - 1'b1) ? '0 : step_cur + 1'b1;
      end else begin
         step_next = (step_cur == '0) ? div - 1'b1 : step_cur - 1'b1;
      end
   end
`endif

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         div         <= DIV_INIT;
         lock_cnt    <= '0;
         locked      <= 1'b0;
         cfg_ready_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            ph[i] <= (i == 1) ? PH1_INIT : PH_INIT;
         end
      end else begin
         cfg_err_q <= 1'b0;

         // Configuration registers: a valid transfer loads even if enable drops now.
         if (xfer && cfg_ok) begin
            div <= cfg.cfg_div;
            for (int i = 0; i < NUM_CH; i++) begin
               ph[i] <= new_ph[i];
            end
         end else if (xfer) begin
            cfg_err_q <= 1'b1;
         end
`ifdef CLKGEN_PHASE_STEP_EN
         else if (step_ok) begin
            ph[step_ch] <= step_next;
         end
`endif

         if (!enable) begin
            state       <= IDLE;
            cnt         <= '0;
            lock_cnt    <= '0;
            locked      <= 1'b0;
            cfg_ready_q <= 1'b0;
         end else if (xfer && cfg_ok) begin
            state       <= ACQ;
            cnt         <= '0;
            lock_cnt    <= '0;
            locked      <= 1'b0;
            cfg_ready_q <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  state       <= ACQ;
                  cnt         <= '0;
                  cfg_ready_q <= 1'b1;
               end
               ACQ: begin
                  if (wrap) begin
                     cnt <= '0;
                     if (lock_cnt == LOCK_LAST) begin
                        state    <= LOCK;
                        locked   <= 1'b1;
                        lock_cnt <= '0;
                     end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               LOCK: begin
                  cnt <= wrap ? '0 : cnt + 1'b1;
               end
               default: begin
                  state       <= IDLE;
                  cnt         <= '0;
                  locked      <= 1'b0;
                  cfg_ready_q <= 1'b0;
               end
            endcase
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      clkgen_phase_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk        (refclk),
         .rst_n      (rst_n),
         .run        (chan_run),
         .cnt        (cnt),
         .div        (div),
         .ph         (ph[g]),
         .outclk     (outclk[g]),
         .outclk_stb (outclk_stb[g])
      );
   end

endmodule

// File: tb/tb_clkgen_multiphase.sv
// tb/tb_clkgen_multiphase.sv - directed table and sequence checks for clkgen_multiphase
module tb_clkgen_multiphase;

   typedef struct {
      logic       en;
      logic [1:0] clk;
      logic [1:0] stb;
      logic       lk;
      logic       err;
      logic       rdy;
   } vec_t;

   logic       refclk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [1:0] outclk;
   logic [1:0] outclk_stb;
   logic       locked;
`ifdef CLKGEN_PHASE_STEP_EN
   logic       step_valid;
   logic [0:0] step_ch;
   logic       step_dir;
`endif

   int n_vec = 0;
   int n_bad = 0;

   vec_t       tbl [31];
   logic [1:0] p6_clk [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
   logic [1:0] p6_stb [6] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
   logic [1:0] p5_clk [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
   logic [1:0] p5_stb [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00};

   clkgen_multiphase_if #(.NUM_CH(2), .CNT_W(8)) cfg_bus ();

   clkgen_multiphase #(
      .NUM_CH        (2),
      .CNT_W         (8),
      .DIV_DEFAULT   (6),
      .PHASE_DEFAULT (0),
      .LOCK_PERIODS  (4)
   ) dut (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .enable     (enable),
      .cfg        (cfg_bus),
`ifdef CLKGEN_PHASE_STEP_EN
      .step_valid (step_valid),
      .step_ch    (step_ch),
      .step_dir   (step_dir),
`endif
      .outclk     (outclk),
      .outclk_stb (outclk_stb),
      .locked     (locked)
   );

   always #5 refclk = ~refclk;

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   // Compares {outclk, outclk_stb, locked, cfg_err, cfg_ready} as one vector.
   task automatic chk(input string nm, input int idx, input logic [1:0] e_clk,
                      input logic [1:0] e_stb, input logic e_lk, input logic e_err,
                      input logic e_rdy);
      logic [6:0] got;
      logic [6:0] exp;
      got = {outclk, outclk_stb, locked, cfg_bus.cfg_err, cfg_bus.cfg_ready};
      exp = {e_clk, e_stb, e_lk, e_err, e_rdy};
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: clk/stb/lock/err/rdy got %b want %b", nm, idx, got, exp);
      end
   endtask

   task automatic send_cfg(input logic [7:0] d, input logic [7:0] p1, input logic [7:0] p0);
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_div   = d;
      cfg_bus.cfg_phase = {p1, p0};
   endtask

   initial begin
      rst_n             = 1'b0;
      enable            = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_div   = '0;
      cfg_bus.cfg_phase = '0;
`ifdef CLKGEN_PHASE_STEP_EN
      step_valid = 1'b0;
      step_ch    = '0;
      step_dir   = 1'b0;
`endif

      tbl[0] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
      for (int n = 1; n < 31; n++) begin
         tbl[n] = '{1'b1, p6_clk[(n-1)%6], p6_stb[(n-1)%6], (n >= 24), 1'b0, 1'b1};
      end

      // Reset values, then one idle edge with enable low
      repeat (2) tick();
      chk("reset", 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("idle", 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

      // Default div=6, ph={0,3}: acquisition and lock after 24 cycles
      for (int n = 0; n < 31; n++) begin
         enable = tbl[n].en;
         tick();
         chk("default", n, tbl[n].clk, tbl[n].stb, tbl[n].lk, tbl[n].err, tbl[n].rdy);
      end

      // Invalid cfg (ph1=7 >= div=6): err pulse only
      send_cfg(8'd6, 8'd7, 8'd0);
      tick();
      chk("bad_cfg", 0, 2'b01, 2'b01, 1'b1, 1'b1, 1'b1);
      cfg_bus.cfg_valid = 1'b0;
      tick();
      chk("bad_cfg", 1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);

      // Valid cfg div=5, ph={0,2} while locked
      send_cfg(8'd5, 8'd2, 8'd0);
      tick();
      chk("cfg5", 1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
      cfg_bus.cfg_valid = 1'b0;
      for (int k = 2; k <= 21; k++) begin
         tick();
         chk("cfg5", k, p5_clk[(k-2)%5], p5_stb[(k-2)%5], (k == 21), 1'b0, 1'b1);
      end

      // Enable drop mid-period, cfg ignored in IDLE, restart at cnt 0
      tick();
      chk("en_drop", 0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1);
      enable = 1'b0;
      tick();
      chk("en_drop", 1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      send_cfg(8'd6, 8'd7, 8'd0);
      tick();
      chk("en_drop", 2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      cfg_bus.cfg_valid = 1'b0;
      enable = 1'b1;
      tick();
      chk("restart", 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("restart", k + 1, p5_clk[k], p5_stb[k], 1'b0, 1'b0, 1'b1);
      end

      // cfg div=9 in ACQ, then async reset returns to defaults
      send_cfg(8'd9, 8'd4, 8'd0);
      tick();
      chk("cfg9", 0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
      cfg_bus.cfg_valid = 1'b0;
      tick();
      chk("cfg9", 1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_rst", 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;
      tick();
      chk("post_rst", 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("post_rst", k + 1, p6_clk[k], p6_stb[k], 1'b0, 1'b0, 1'b1);
      end

`ifdef CLKGEN_PHASE_STEP_EN
      // div=6, ph={0,5}; once locked, step ch1 +1 wraps it to 0
      send_cfg(8'd6, 8'd5, 8'd0);
      tick();
      chk("step", 0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
      cfg_bus.cfg_valid = 1'b0;
      repeat (24) tick();
      chk("step", 1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1);
      step_valid = 1'b1;
      step_ch    = 1'b1;
      step_dir   = 1'b1;
      tick();
      chk("step", 2, 2'b11, 2'b01, 1'b1, 1'b0, 1'b1);
      step_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         logic [1:0] ec;
         logic [1:0] es;
         ec = (k < 2 || k == 5) ? 2'b11 : 2'b00;
         es = (k == 5) ? 2'b11 : 2'b00;
         tick();
         chk("step", k + 3, ec, es, 1'b1, 1'b0, 1'b1);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
